// File: rtl/rom_download_writer_pkg.sv
// Shared types for the ROM download path: SDRAM/ioctl widths, the buffered word
// record and the SDRAM write FSM states.
package tecmo_pkg;

    localparam int SDRAM_ADDR_W = 23;
    localparam int SDRAM_DATA_W = 32;
    localparam int IOCTL_ADDR_W = 20;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] data;
    } dl_word_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_REQ  = 1'b1
    } wr_state_t;

    // Each 32-bit ROM word covers two 16-bit SDRAM words; the sum wraps at 2^23.
    function automatic logic [SDRAM_ADDR_W-1:0] rom_sdram_addr(
        input logic [SDRAM_ADDR_W-1:0] base,
        input logic [IOCTL_ADDR_W-3:0] word_addr
    );
        return base + {4'b0000, word_addr, 1'b0};
    endfunction

endpackage

// File: rtl/rom_download_writer_if.sv
// SDRAM write request channel. The master raises req together with we, addr and
// data and holds all of them stable until it samples ack high; ack is a one-cycle
// acceptance pulse, after which req drops. Ack while req is low has no meaning.
interface rom_download_writer_if;
    import tecmo_pkg::*;

    logic [SDRAM_ADDR_W-1:0] sdram_addr;
    logic [SDRAM_DATA_W-1:0] sdram_data;
    logic                    sdram_we;
    logic                    sdram_req;
    logic                    sdram_ack;

    modport master (
        output sdram_addr, sdram_data, sdram_we, sdram_req,
        input  sdram_ack
    );

    modport slave (
        input  sdram_addr, sdram_data, sdram_we, sdram_req,
        output sdram_ack
    );

endinterface

// File: rtl/rom_download_writer_fifo.sv
// Small synchronous FIFO of packed download words; head comes straight from the
// storage registers and full/empty are decoded from the occupancy count.
module dl_word_fifo
    import tecmo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  dl_word_t                    push_word,
    input  logic                        pop,
    output dl_word_t                    head,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int PW = $clog2(FIFO_DEPTH);

    dl_word_t        mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

endmodule

// File: rtl/rom_download_writer.sv
// Packs the ioctl ROM byte stream into 32-bit words and writes them to SDRAM.
// Define ROM_CHECKSUM_EN to add a 16-bit byte checksum output.
module rom_download_writer
    import tecmo_pkg::*;
#(
    parameter int                      FIFO_DEPTH = 4,
    parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR  = 23'h000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]              ioctl_data,
    output logic                    ioctl_wait,
    rom_download_writer_if.master   sdram,
    output logic                    busy,
    output wr_state_t               dbg_state
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]             checksum
`endif
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAW = IOCTL_ADDR_W - 2;

    logic                    dl_d;
    logic                    byte_acc;
    logic                    dl_fall;
    logic                    addr_change;
    logic [WAW-1:0]          word_addr;
    logic [WAW-1:0]          new_waddr;
    logic [1:0]              lane;
    logic [31:0]             pack_data;
    logic [31:0]             lane_data;
    logic [31:0]             lane_keep;
    logic [31:0]             merged;
    logic [3:0]              lane_mask;
    logic [3:0]              lane_bit;
    logic [3:0]              merged_mask;
    logic                    push_valid;
    dl_word_t                push_word;
    dl_word_t                fifo_head;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             occupancy;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    wr_state_t               state;
    wr_state_t               state_nx;
    logic                    req_r;
    logic                    we_r;
    logic [SDRAM_ADDR_W-1:0] addr_r;
    logic [SDRAM_DATA_W-1:0] data_r;

    assign byte_acc    = ioctl_wr & ioctl_download;
    assign dl_fall     = dl_d & ~ioctl_download;
    assign lane        = ioctl_addr[1:0];
    assign new_waddr   = ioctl_addr[IOCTL_ADDR_W-1:2];
    assign lane_bit    = 4'b0001 << lane;
    assign lane_data   = {24'h000000, ioctl_data} << {lane, 3'b000};
    assign lane_keep   = ~(32'h0000_00FF << {lane, 3'b000});
    assign merged      = (pack_data & lane_keep) | lane_data;
    assign merged_mask = lane_mask | lane_bit;
    assign addr_change = (lane_mask != 4'h0) && (new_waddr != word_addr);

    // A byte for a new word evicts the partial word and seeds the next one in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_d       <= 1'b0;
            word_addr  <= '0;
            pack_data  <= '0;
            lane_mask  <= '0;
            push_valid <= 1'b0;
            push_word  <= '0;
        end else begin
            dl_d       <= ioctl_download;
            push_valid <= 1'b0;
            if (byte_acc) begin
                word_addr <= new_waddr;
                if (addr_change) begin
                    push_valid <= 1'b1;
                    push_word  <= '{addr: rom_sdram_addr(BASE_ADDR, word_addr), data: pack_data};
                    pack_data  <= lane_data;
                    lane_mask  <= lane_bit;
                end else if (merged_mask == 4'hF) begin
                    push_valid <= 1'b1;
                    push_word  <= '{addr: rom_sdram_addr(BASE_ADDR, new_waddr), data: merged};
                    pack_data  <= '0;
                    lane_mask  <= '0;
                end else begin
                    pack_data  <= merged;
                    lane_mask  <= merged_mask;
                end
            end else if (dl_fall && (lane_mask != 4'h0)) begin
                push_valid <= 1'b1;
                push_word  <= '{addr: rom_sdram_addr(BASE_ADDR, word_addr), data: pack_data};
                pack_data  <= '0;
                lane_mask  <= '0;
            end
        end
    end

    dl_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_valid),
        .push_word (push_word),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Counting the in-flight push register keeps one more word always placeable.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(push_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ioctl_wait <= 1'b0;
        else          ioctl_wait <= (occupancy >= (CW+1)'(FIFO_DEPTH - 1));
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            WR_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = WR_REQ;
                end
            end
            WR_REQ: begin
                if (sdram.sdram_ack) state_nx = WR_IDLE;
            end
            default: state_nx = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= WR_IDLE;
            req_r  <= 1'b0;
            we_r   <= 1'b0;
            addr_r <= '0;
            data_r <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                req_r  <= 1'b1;
                we_r   <= 1'b1;
                addr_r <= fifo_head.addr;
                data_r <= fifo_head.data;
            end else if ((state == WR_REQ) && sdram.sdram_ack) begin
                req_r <= 1'b0;
                we_r  <= 1'b0;
            end
        end
    end

    assign sdram.sdram_req  = req_r;
    assign sdram.sdram_we   = we_r;
    assign sdram.sdram_addr = addr_r;
    assign sdram.sdram_data = data_r;
    assign dbg_state        = state;
    assign busy             = dl_d | push_valid | (lane_mask != 4'h0) | ~fifo_empty | req_r;

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_base;

    assign sum_base = (ioctl_download & ~dl_d) ? 16'h0000 : checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) checksum <= 16'h0000;
        else          checksum <= sum_base + (byte_acc ? {8'h00, ioctl_data} : 16'h0000);
    end
`endif

endmodule

// File: tb/tb_rom_download_writer.sv
// Bench for rom_download_writer: byte-stream word model with an expected-write
// queue, a cycle monitor/ack responder, and directed scenarios with literal results.
module tb_rom_download_writer;
    import tecmo_pkg::*;

    localparam int W          = 55;
    localparam int FIFO_DEPTH = 4;
    localparam int BASE0      = 0;

    logic        clk;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [19:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic        busy;
    wr_state_t   dut_state;

    logic        w_download;
    logic        w_wr;
    logic [19:0] w_addr;
    logic [7:0]  w_data;
    logic        w_wait;
    logic        w_busy;
    wr_state_t   w_state;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] w_checksum;
`endif

    rom_download_writer_if sdr ();
    rom_download_writer_if sdr_w ();

    rom_download_writer #(.FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(23'h000000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .sdram          (sdr.master),
        .busy           (busy),
        .dbg_state      (dut_state)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    rom_download_writer #(.FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(23'h7FFFFE)) dut_w (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (w_download),
        .ioctl_wr       (w_wr),
        .ioctl_addr     (w_addr),
        .ioctl_data     (w_data),
        .ioctl_wait     (w_wait),
        .sdram          (sdr_w.master),
        .busy           (w_busy),
        .dbg_state      (w_state)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum       (w_checksum)
`endif
    );

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q [$];
    logic [W-1:0]   wr_log [$];
    logic [W-1:0]   w_log [$];
    int             produced = 0;
    int             acked = 0;
    int             ack_delay = 2;
    int             ack_cnt = 0;
    logic           ack_hold = 1'b0;
    logic           prev_req = 1'b0;
    logic           wait_seen = 1'b0;
    logic [W-1:0]   cap;
    logic [W-1:0]   e;
    logic [31:0]    m_data = '0;
    logic [3:0]     m_mask = '0;
    logic [17:0]    m_w = '0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // word model: bytes grouped by ioctl_addr[19:2], emitted on full, on word change, on flush
    function automatic void emit(input logic [17:0] w, input logic [31:0] d);
        logic [22:0] a;
        a = 23'((BASE0 + 32'(w) * 2) % (1 << 23));
        exp_q.push_back({a, d});
        produced++;
    endfunction

    function automatic void model_byte(input logic [19:0] a, input logic [7:0] d);
        int ln;
        ln = int'(a[1:0]);
        if (m_mask != 4'h0 && a[19:2] != m_w) begin
            emit(m_w, m_data);
            m_mask = 4'h0;
            m_data = '0;
        end
        m_w = a[19:2];
        m_data[ln*8 +: 8] = d;
        m_mask[ln] = 1'b1;
        if (m_mask == 4'hF) begin
            emit(m_w, m_data);
            m_mask = 4'h0;
            m_data = '0;
        end
    endfunction

    // driver tasks (entered at posedge + 1)
    task automatic send_byte(input logic [19:0] a, input logic [7:0] d);
        int guard;
        guard = 0;
        while (ioctl_wait && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) check("wait_timeout", 64'(ioctl_wait), 64'd0);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        model_byte(a, d);
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        if (m_mask != 4'h0) begin
            emit(m_w, m_data);
            m_mask = 4'h0;
            m_data = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    // monitor + ack responder + scoreboard compare
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_req      = 1'b0;
            ack_cnt       = 0;
            sdr.sdram_ack = 1'b0;
        end else begin
            check("we_tracks_req", 64'(sdr.sdram_we), 64'(sdr.sdram_req));
            if (sdr.sdram_req && !prev_req) begin
                cap = {sdr.sdram_addr, sdr.sdram_data};
                wr_log.push_back(cap);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(cap), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(sdr.sdram_addr), 64'(e[54:32]));
                    check("wr_data", 64'(sdr.sdram_data), 64'(e[31:0]));
                end
            end else if (sdr.sdram_req) begin
                check("req_stable", 64'({sdr.sdram_addr, sdr.sdram_data}), 64'(cap));
            end
            if (ioctl_wait) begin
                wait_seen = 1'b1;
                check("wait_threshold", 64'((produced - acked) >= FIFO_DEPTH - 1), 64'd1);
            end
            if (dut.u_fifo.push && dut.u_fifo.full) begin
                errors++;
                $display("FAIL push_to_full got 1 want 0");
            end
            if (sdr.sdram_ack) begin
                sdr.sdram_ack = 1'b0;
            end else if (sdr.sdram_req && !ack_hold) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    sdr.sdram_ack = 1'b1;
                    ack_cnt = 0;
                    acked++;
                end
            end
            prev_req = sdr.sdram_req;
        end
    end

    // second instance: ack one cycle after every request
    always @(negedge clk) begin
        if (sdr_w.sdram_req && !sdr_w.sdram_ack) begin
            w_log.push_back({sdr_w.sdram_addr, sdr_w.sdram_data});
            sdr_w.sdram_ack = 1'b1;
        end else begin
            sdr_w.sdram_ack = 1'b0;
        end
    end

    initial begin
        reset_n = 1'b0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        w_download = 1'b0; w_wr = 1'b0; w_addr = '0; w_data = '0;
        sdr.sdram_ack = 1'b0;
        sdr_w.sdram_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 64'(sdr.sdram_req), 64'd0);
        check("rst_we", 64'(sdr.sdram_we), 64'd0);
        check("rst_addr", 64'(sdr.sdram_addr), 64'd0);
        check("rst_data", 64'(sdr.sdram_data), 64'd0);
        check("rst_wait", 64'(ioctl_wait), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(dut_state), 64'(WR_IDLE));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // sequential bytes 11..88
        start_dl();
        check("busy_in_dl", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) send_byte(20'(i), 8'(8'h11 * (i + 1)));
        end_dl();
        wait_idle("busy_after_seq");
        check("seq_count", 64'(wr_log.size()), 64'd2);
        check("seq_w0", 64'(wr_log[0]), 64'({23'h000000, 32'h44332211}));
        check("seq_w1", 64'(wr_log[1]), 64'({23'h000002, 32'h88776655}));
        wr_log.delete();

        // partial word evicted by a jump, then flush on download end
        start_dl();
        send_byte(20'd0, 8'h11);
        send_byte(20'd1, 8'h22);
        send_byte(20'd8, 8'h5A);
        end_dl();
        wait_idle("busy_after_partial");
        check("part_count", 64'(wr_log.size()), 64'd2);
        check("part_w0", 64'(wr_log[0]), 64'({23'h000000, 32'h00002211}));
        check("part_w1", 64'(wr_log[1]), 64'({23'h000004, 32'h0000005A}));
        wr_log.delete();

        // backpressure: ack withheld for 50 cycles during a 32-byte stream
        ack_hold = 1'b1;
        wait_seen = 1'b0;
        start_dl();
        fork
            begin
                for (int i = 0; i < 32; i++) send_byte(20'(i), 8'(i * 3 + 1));
            end
            begin
                repeat (50) @(posedge clk);
                #1;
                check("stall_wait_high", 64'(ioctl_wait), 64'd1);
                check("stall_one_req", 64'(wr_log.size()), 64'd1);
                check("stall_wait_seen", 64'(wait_seen), 64'd1);
                ack_hold = 1'b0;
            end
        join
        end_dl();
        wait_idle("busy_after_stall");
        check("stall_count", 64'(wr_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) check("stall_addr", 64'(wr_log[i][54:32]), 64'(2 * i));
        check("stall_wait_low", 64'(ioctl_wait), 64'd0);
        wr_log.delete();

        // address wrap on the BASE_ADDR=7FFFFE instance
        w_download = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            w_wr = 1'b1; w_addr = 20'(4 + i); w_data = 8'(8'hA1 + i);
            @(posedge clk);
            #1;
        end
        w_wr = 1'b0;
        w_download = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("wrap_count", 64'(w_log.size()), 64'd1);
        check("wrap_word", 64'(w_log[0]), 64'({23'h000000, 32'hA4A3A2A1}));
        check("wrap_busy", 64'(w_busy), 64'd0);

        // asynchronous reset in the middle of a request
        ack_hold = 1'b1;
        start_dl();
        for (int i = 0; i < 16; i++) send_byte(20'(i), 8'(8'hC0 + i));
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_req", 64'(sdr.sdram_req), 64'd1);
        check("pre_rst_wait", 64'(ioctl_wait), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_req", 64'(sdr.sdram_req), 64'd0);
        check("async_rst_wait", 64'(ioctl_wait), 64'd0);
        check("async_rst_we", 64'(sdr.sdram_we), 64'd0);
        exp_q.delete();
        wr_log.delete();
        produced = 0; acked = 0;
        m_mask = 4'h0; m_data = '0; m_w = '0;
        ioctl_download = 1'b0;
        ack_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start_dl();
        for (int i = 0; i < 4; i++) send_byte(20'(i), 8'(i + 1));
        end_dl();
        wait_idle("busy_after_rst");
        check("post_rst_count", 64'(wr_log.size()), 64'd1);
        check("post_rst_word", 64'(wr_log[0]), 64'({23'h000000, 32'h04030201}));
        wr_log.delete();

`ifdef ROM_CHECKSUM_EN
        start_dl();
        send_byte(20'd0, 8'hFF);
        send_byte(20'd1, 8'hFF);
        send_byte(20'd2, 8'h02);
        end_dl();
        wait_idle("busy_after_csum");
        check("csum_value", 64'(checksum), 64'h0200);
        start_dl();
        check("csum_clear", 64'(checksum), 64'h0000);
        end_dl();
        wait_idle("busy_after_csum2");
`endif

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
